// File: rtl/rsa_modexp_engine.sv
// rtl/rsa_modexp_engine.sv - modular exponentiation engine, res = base^e mod n
//
// Left-to-right square-and-multiply over a bit-serial interleaved modular
// multiplier. Each modular product takes exactly WIDTH cycles.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake
//   cmd_type            0 encrypt cmd_data, 1 load e, 2 load n, 3 ignored
//   cmd_data            operand / load value
//   res_valid/res_ready result handshake
//   res_data            base^e mod n (0 on error)
//   res_err             n < 2 at command time
//   busy                exponentiation in progress
module rsa_modexp_engine #(
  parameter int WIDTH      = 16,
  parameter int EXP_WIDTH  = 16,
  parameter int E_RESET    = 17,
  parameter int N_RESET    = 3233,
  parameter int CONST_TIME = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_type,
  input  logic [WIDTH-1:0]     cmd_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic                 res_err,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam bit CT = (CONST_TIME != 0);

  typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_SQUARE, S_MULT, S_DONE} state_t;

  state_t               state;
  logic [EXP_WIDTH-1:0] e_reg;
  logic [EXP_WIDTH-1:0] e_sh;
  logic [WIDTH-1:0]     n_reg;
  logic [BW-1:0]        bit_cnt;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     base_r;
  logic [WIDTH-1:0]     mm_r;
  logic [CW-1:0]        mm_cnt;
  logic                 prime;

  // Multiplier operand selection per phase. REDUCE multiplies the raw base by 1,
  // so the base is the scanned operand and the added term is always < n.
  logic [WIDTH-1:0] mm_mplier;
  logic [WIDTH-1:0] mm_mcand;
  logic             mm_bit;
  logic [WIDTH:0]   r2;
  logic             r2_ge;
  logic [WIDTH-1:0] r2s;
  logic [WIDTH:0]   r3;
  logic             r3_ge;
  logic [WIDTH-1:0] mm_next;
  logic [WIDTH-1:0] new_acc;
  logic             take_mult;

  always_comb begin
    mm_mplier = acc;
    mm_mcand  = acc;
    if (state == S_REDUCE) begin
      mm_mplier = base_r;
      mm_mcand  = WIDTH'(1);
    end else if (state == S_MULT) begin
      mm_mcand  = base_r;
    end
  end

  // One interleaved step: R = 2R mod n, then R = (R + bit*mcand) mod n.
  // Both intermediate sums are < 2n, so one conditional subtract suffices and
  // the true result always fits in WIDTH bits.
  always_comb begin
    mm_bit  = mm_mplier[mm_cnt];
    r2      = {mm_r, 1'b0};
    r2_ge   = (r2 >= {1'b0, n_reg});
    r2s     = r2_ge ? (r2[WIDTH-1:0] - n_reg) : r2[WIDTH-1:0];
    r3      = {1'b0, r2s} + (mm_bit ? {1'b0, mm_mcand} : '0);
    r3_ge   = (r3 >= {1'b0, n_reg});
    mm_next = r3_ge ? (r3[WIDTH-1:0] - n_reg) : r3[WIDTH-1:0];
  end

  // Accumulator value at the end of the current phase; in constant-time mode
  // the multiply for a 0 bit is performed but its product is dropped here.
  always_comb begin
    new_acc = acc;
    if (state == S_SQUARE) begin
      new_acc = mm_next;
    end else if (state == S_MULT && e_sh[EXP_WIDTH-1]) begin
      new_acc = mm_next;
    end
  end

  assign take_mult = e_sh[EXP_WIDTH-1] || CT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      e_reg     <= EXP_WIDTH'(E_RESET);
      n_reg     <= WIDTH'(N_RESET);
      e_sh      <= '0;
      bit_cnt   <= '0;
      acc       <= '0;
      base_r    <= '0;
      mm_r      <= '0;
      mm_cnt    <= '0;
      prime     <= 1'b0;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            case (cmd_type)
              2'd0: begin
                cmd_ready <= 1'b0;
                if (n_reg < WIDTH'(2)) begin
                  // Error result is presented from DONE one cycle later.
                  state <= S_DONE;
                end else begin
                  state   <= S_REDUCE;
                  busy    <= 1'b1;
                  base_r  <= cmd_data;
                  acc     <= WIDTH'(1);
                  e_sh    <= e_reg;
                  bit_cnt <= BW'(EXP_WIDTH - 1);
                  mm_r    <= '0;
                  mm_cnt  <= CW'(WIDTH - 1);
                  // One setup cycle before the first multiplier step.
                  prime   <= 1'b1;
                end
              end
              2'd1: e_reg <= cmd_data[EXP_WIDTH-1:0];
              2'd2: n_reg <= cmd_data;
              default: ;
            endcase
          end
        end

        S_REDUCE, S_SQUARE, S_MULT: begin
          if (prime) begin
            prime <= 1'b0;
          end else if (mm_cnt != '0) begin
            mm_r   <= mm_next;
            mm_cnt <= mm_cnt - 1'b1;
          end else begin
            mm_r   <= '0;
            mm_cnt <= CW'(WIDTH - 1);
            acc    <= new_acc;
            if (state == S_REDUCE) begin
              base_r <= mm_next;
              state  <= S_SQUARE;
            end else if (state == S_SQUARE && take_mult) begin
              state <= S_MULT;
            end else if (bit_cnt == '0) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              res_valid <= 1'b1;
              res_err   <= 1'b0;
              res_data  <= new_acc;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              e_sh    <= e_sh << 1;
              state   <= S_SQUARE;
            end
          end
        end

        S_DONE: begin
          if (!res_valid) begin
            // Only the n < 2 path arrives here without a result.
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_data  <= '0;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rsa_modexp_engine.md
Name: rsa_modexp_engine

Overview:
Parametrised modular-exponentiation engine computing res = base^e mod n. It replaces the fixed controller/datapath pair with a single block that has:
- valid/ready command and result handshakes;
- loadable e and n;
- left-to-right square-and-multiply over a sequential interleaved modular multiplier;
- an optional constant-time mode.

It sits between the host command interface and the downstream result consumer.

Parameters:
WIDTH, 16, bit width of base, n and result; n must be < 2^WIDTH
EXP_WIDTH, 16, bit width of exponent register; must be <= WIDTH
E_RESET, 17, exponent value after reset
N_RESET, 3233, modulus value after reset
CONST_TIME, 0, 1 = always perform multiply step regardless of exponent bit (discard if bit = 0)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  engine can accept a command
cmd_type  input  2  0 = encrypt cmd_data, 1 = load e, 2 = load n, 3 = reserved (accepted, ignored)
cmd_data  input  WIDTH  operand; load e uses bits [EXP_WIDTH-1:0]
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  base^e mod n
res_err  output  1  result invalid (n < 2)
busy  output  1  exponentiation in progress

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; e = E_RESET; n = N_RESET.
  - cmd_ready = 1 after release; res_valid = 0; res_data = 0; res_err = 0; busy = 0.
  - Reset asserted mid-operation aborts the operation immediately; no partial result is ever presented.
- Command acceptance:
  - A command is accepted on a rising edge where cmd_valid & cmd_ready.
  - cmd_ready = 1 only in IDLE with res_valid = 0.
- Load e / load n / reserved: register updates on the accepting edge, stays IDLE, no result produced. Loads are not range-checked.
- Encrypt, n < 2:
  - Next state is DONE: res_valid = 1, res_err = 1, res_data = 0 on the edge after acceptance.
- Encrypt, n >= 2: states REDUCE -> SQUARE -> MULT -> ... -> DONE.
  - REDUCE: base_r = cmd_data*1 mod n via modmul (this handles base >= n); acc = 1.
  - Exponent scanned MSB to LSB over all EXP_WIDTH bits. Per bit:
    - SQUARE: acc = acc*acc mod n.
    - MULT: acc = acc*base_r mod n. Executed when the bit is 1, or always if CONST_TIME = 1, in which case the product is discarded for a 0 bit.
  - After the last bit -> DONE: res_data = acc, res_err = 0.
- modmul: exactly WIDTH cycles. Interleaved, over multiplier bits MSB first: R = 2R; if R >= n then R -= n; if bit then R += multiplicand; if R >= n then R -= n. Internal R is WIDTH+1 bits; no overflow permitted.
- Latency from accept edge to res_valid rising:
  - 1 + WIDTH*(1 + EXP_WIDTH + k) cycles.
  - k = popcount(e) if CONST_TIME = 0, else EXP_WIDTH.
- busy = 1 in REDUCE/SQUARE/MULT, 0 otherwise.
- e = 0 gives result 1 (n >= 2).
- e and n are sampled at command acceptance; they cannot change mid-operation because cmd_ready = 0.
- DONE: res_valid, res_data and res_err are held stable until res_valid & res_ready on an edge. That edge clears res_valid and moves to IDLE; cmd_ready rises on the following cycle. No result is ever dropped.

Test Plan:
1. Defaults, CONST_TIME = 0: encrypt 65 -> res_data = 2790, res_err = 0, res_valid 305 cycles after accept. Repeat with CONST_TIME = 1 -> 2790 at 529 cycles.
2. Sweep with defaults: encrypt 0..255 -> res_data = i^17 mod 3233 for every i; check busy high throughout and cmd_ready low until the result handshake.
3. Load e = 3, then n = 15, then encrypt 0..14 -> i^3 mod 15 (e.g. 7 -> 13, 2 -> 8); encrypt 22 -> 13 (base reduction).
4. Edge values:
   - n = 1, encrypt 5 -> res_err = 1, res_data = 0, res_valid on the cycle after accept.
   - n = 0 gives the same response.
   - n = 15, e = 0, encrypt 9 -> 1.
   - n = 65521, e = 65535, encrypt 65535 -> golden-model value.
5. Backpressure: hold res_ready = 0 for 100 cycles after res_valid -> res_data/res_err stable, cmd_ready = 0, and encrypt/load commands are not accepted (e unchanged).
6. Reset mid-operation: drop rst_n 100 cycles into an encrypt after loading e = 3 -> all outputs reset immediately. After release, encrypt 65 -> 2790, showing e/n restored to 17/3233.
